// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher feeding a small prefetch FIFO; the consumer pops
// from the head while fetch_pc walks memory, with redirect flushing the FIFO.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic [31:0]              mem_address,
    input  logic [31:0]              mem_instruction,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst_out,
    output logic [31:0]              inst_pc,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     dbg_state_o
);

    // Handshake: an entry transfers at a rising edge when inst_valid && inst_ready
    // and redirect is low; inst_out/inst_pc are held until that transfer happens.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem_q  [DEPTH];
    logic [31:0]     ins_mem_q [DEPTH];
    logic            push;
    logic            pop;

    always_comb begin
        pop        = (count_q != '0) && inst_ready && !redirect;
        push       = (state_q == RUN) && !redirect && ((count_q != FULL) || pop);
        state_d    = fetch_en ? RUN : IDLE;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
                wr_ptr_d   = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
            ins_mem_q[wr_ptr_q] <= mem_instruction;
        end
    end

    assign mem_address = fetch_pc_q;
    assign inst_valid  = (count_q != '0);
    assign inst_out    = inst_valid ? ins_mem_q[rd_ptr_q] : 32'd0;
    assign inst_pc     = inst_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
    assign buf_count   = count_q;
    assign dbg_state_o = (state_q == RUN);

endmodule
